// File: rtl/gfx_pkg.sv
// Shared fixed-point types and constants for the geometry pipeline.
// Q16.16 vertex words, vector bundles and the perspective-divide state set.
package gfx_pkg;

  typedef logic [31:0] fx32_t;
  typedef fx32_t [0:3] vec4_t;
  typedef fx32_t [0:2] vec3_t;

  localparam fx32_t FX_ONE = 32'h0001_0000;
  localparam fx32_t FX_MAX = 32'h7FFF_FFFF;
  localparam fx32_t FX_MIN = 32'h8000_0000;

  localparam int DEF_ITERS = 48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_OUT
  } pd_state_t;

  // 0x8000_0000 maps to 2^31 as an unsigned magnitude.
  function automatic logic [31:0] fx_mag(input fx32_t v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider: 48-bit dividend by 32-bit divisor,
// one quotient bit per clock.
module seq_div
  import gfx_pkg::*;
#(
  parameter int ITERS = DEF_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [47:0] quotient,
  output logic        dz
);

  localparam int CW = $clog2(ITERS + 1);

  logic [47:0] qd;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [CW-1:0] cnt;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        ge;

  assign rem_sh = {rem, qd[47]};
  assign trial  = rem_sh - {1'b0, dsr};
  assign ge     = rem_sh >= {1'b0, dsr};

  // High during the cycle whose edge shifts in the last bit.
  assign done     = busy && (cnt == CW'(1));
  assign quotient = qd;

  always_ff @(posedge clk) begin
    if (rst) begin
      qd   <= '0;
      rem  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      dz   <= 1'b0;
    end else if (start) begin
      qd   <= dividend;
      rem  <= '0;
      dsr  <= divisor;
      cnt  <= CW'(ITERS);
      busy <= 1'b1;
      dz   <= (divisor == '0);
    end else if (busy) begin
      rem <= ge ? trial[31:0] : rem_sh[31:0];
      qd  <= {qd[46:0], ge};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/persp_div.sv
// Perspective divide: x/w, y/w, z/w in Q16.16 with a fixed
// 147-cycle latency, one shared sequential divider.
module persp_div
  import gfx_pkg::*;
#(
  parameter int FRAC_BITS = 16,
  parameter int ITERS     = DEF_ITERS
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  vec4_t in_vec,
  output logic  in_ready,
  output logic  out_valid,
  input  logic  out_ready,
  output vec3_t out_vec,
  output logic  out_dz
);

  pd_state_t state, nxt;

  vec4_t       v;
  logic [1:0]  idx;
  logic        ld;
  logic [47:0] raw_x;
  logic [47:0] raw_y;

  logic        start, busy, done, dz;
  logic [47:0] q;
  logic [47:0] dvd;

  assign dvd   = 48'(fx_mag(v[idx])) << FRAC_BITS;
  assign start = (state == S_DIV) && ld && !busy;

  seq_div #(.ITERS(ITERS)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dvd),
    .divisor  (fx_mag(v[3])),
    .busy     (busy),
    .done     (done),
    .quotient (q),
    .dz       (dz)
  );

  // Sign and saturation are applied to the unsigned quotient.
  function automatic fx32_t fin(input fx32_t n, input logic ws,
                                input logic [47:0] mq, input logic z);
    if (z)
      return (n == '0) ? '0 : (n[31] ? FX_MIN : FX_MAX);
    if (n[31] ^ ws)
      return (mq > 48'h7FFF_FFFF) ? FX_MIN : (~mq[31:0] + 32'd1);
    return (mq > 48'h7FFF_FFFF) ? FX_MAX : mq[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (in_valid) nxt = S_DIV;
      S_DIV:  if (done && idx == 2'd2) nxt = S_OUT;
      S_OUT:  if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_OUT);
    out_vec   = '0;
    out_dz    = 1'b0;
    if (state == S_OUT) begin
      out_vec[0] = fin(v[0], v[3][31], raw_x, dz);
      out_vec[1] = fin(v[1], v[3][31], raw_y, dz);
      out_vec[2] = fin(v[2], v[3][31], q, dz);
      out_dz     = dz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      idx   <= '0;
      ld    <= 1'b0;
      raw_x <= '0;
      raw_y <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        v   <= in_vec;
        idx <= '0;
        ld  <= 1'b1;
      end
      // Each load edge banks the previous component's quotient.
      if (start) begin
        ld <= 1'b0;
        if (idx == 2'd1) raw_x <= q;
        if (idx == 2'd2) raw_y <= q;
      end
      if (state == S_DIV && done) begin
        idx <= idx + 2'd1;
        ld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_persp_div.sv
// Self-checking bench for persp_div against an arithmetic
// reference of the Q16.16 perspective divide.
module tb_persp_div;
  import gfx_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  vec4_t in_vec = '0;
  logic  in_ready;
  logic  out_valid;
  logic  out_ready = 1'b0;
  vec3_t out_vec;
  logic  out_dz;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int LAT = 147;

  always #5 clk = ~clk;

  persp_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_dz    (out_dz)
  );

  function automatic fx32_t ref_div(input fx32_t n, input fx32_t w);
    longint sn, sw, qq;
    if (w == 32'd0)
      return (n == 32'd0) ? 32'd0 : (n[31] ? FX_MIN : FX_MAX);
    sn = longint'($signed(n));
    sw = longint'($signed(w));
    qq = (sn * 65536) / sw;
    if (qq > 64'sd2147483647)  return FX_MAX;
    if (qq < -64'sd2147483648) return FX_MIN;
    return qq[31:0];
  endfunction

  function automatic vec3_t ref_vec(input vec4_t v);
    vec3_t r;
    for (int i = 0; i < 3; i++) r[i] = ref_div(v[i], v[3]);
    return r;
  endfunction

  task automatic send(input vec4_t v, output vec3_t o,
                      output logic z, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 400) begin
      @(posedge clk); #1; g++;
    end
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    o = out_vec;
    z = out_dz;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_vec !== '0 || out_dz !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b vec=%h dz=%b req 0/0/0",
               out_valid, out_vec, out_dz);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b req 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec4_t v [5];
    vec3_t o, e;
    logic  z;
    int    lat;
    v[0] = '{32'h0002_0000, 32'h0004_0000, 32'hFFFA_0000, 32'h0002_0000};
    v[1] = '{FX_ONE, 32'h0, 32'hFFFF_0000, 32'hFFFF_0000};
    v[2] = '{32'h0003_0000, 32'h0, 32'hFFFF_0000, 32'h0};
    v[3] = '{32'h7FFF_0000, 32'h0, 32'h0, 32'h0000_0100};
    v[4] = '{FX_ONE, FX_MIN, FX_MIN, 32'h0003_0000};
    for (int k = 0; k < 5; k++) begin
      send(v[k], o, z, lat);
      e = ref_vec(v[k]);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (o[i] !== e[i]) begin
          n_bad++;
          $display("FAIL directed%0d_c%0d got %h req %h", k, i, o[i], e[i]);
        end
      end
      n_cmp++;
      if (z !== (v[k][3] == 32'd0)) begin
        n_bad++;
        $display("FAIL directed%0d_dz got %b req %b", k, z, v[k][3] == 0);
      end
      n_cmp++;
      if (lat != LAT) begin
        n_bad++;
        $display("FAIL directed%0d_latency got %0d req %0d", k, lat, LAT);
      end
      drain();
    end
  endtask

  task automatic test_stall();
    vec4_t v1, v2;
    vec3_t o, e;
    logic  z;
    int    lat;
    int    bad;
    v1 = '{32'h0005_0000, 32'hFFFD_8000, 32'h0001_0000, 32'h0002_0000};
    v2 = '{32'h0009_0000, 32'h0003_0000, 32'hFFF7_0000, 32'h0003_0000};
    send(v1, o, z, lat);
    e = ref_vec(v1);
    in_valid = 1'b1;
    in_vec   = v2;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_vec !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stall_hold got %0d bad cycles req 0 (vec=%h)",
               bad, out_vec);
    end
    in_valid = 1'b0;
    drain();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_release got rdy=%b vld=%b req 1/0",
               in_ready, out_valid);
    end
    send(v2, o, z, lat);
    e = ref_vec(v2);
    n_cmp++;
    if (o !== e || lat != LAT) begin
      n_bad++;
      $display("FAIL back_to_back got %h lat %0d req %h lat %0d",
               o, lat, e, LAT);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    vec4_t v1, v2;
    vec3_t o, e;
    logic  z;
    int    lat;
    v1 = '{32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0001_0000};
    v2 = '{FX_ONE, 32'h0006_0000, 32'hFFFE_0000, 32'h0003_0000};
    in_valid = 1'b1;
    in_vec   = v1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got vld=%b rdy=%b vec=%h req 0/1/0",
               out_valid, in_ready, out_vec);
    end
    send(v2, o, z, lat);
    e = ref_vec(v2);
    n_cmp++;
    if (o !== e || z !== 1'b0 || lat != LAT) begin
      n_bad++;
      $display("FAIL after_reset got %h dz %b lat %0d req %h dz 0 lat %0d",
               o, z, lat, e, LAT);
    end
    drain();
  endtask

  task automatic test_random();
    vec4_t v;
    vec3_t o, e;
    logic  z;
    int    lat;
    int    mode;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 4; i++) v[i] = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) v[3] = 32'd0;
      if (mode == 1) v[3] = $urandom_range(1, 32'h0000_0400);
      if (mode == 2) begin
        v[0] = FX_MIN;
        v[3] = ($urandom_range(0, 1) != 0) ? FX_MIN : 32'hFFFF_FFFF;
      end
      if (mode == 3) v[1] = 32'd0;
      send(v, o, z, lat);
      e = ref_vec(v);
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL random%0d_vec in %h got %h req %h", k, v, o, e);
      end
      n_cmp++;
      if (z !== (v[3] == 32'd0) || lat != LAT) begin
        n_bad++;
        $display("FAIL random%0d_dz_lat got dz %b lat %0d req dz %b lat %0d",
                 k, z, lat, v[3] == 0, LAT);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/persp_div.md
PERSP_DIV -- requirements
Module: persp_div

Interface
REQ-001 Parameter FRAC_BITS, default 16, number of fractional bits in the signed fixed-point vertex format (Q16.16).
REQ-002 Parameter ITERS, default 48, number of quotient bits produced per component division.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream vertex-transform result vector is present on in_vec.
REQ-006 in_vec  input  [0:3][31:0]  clip-space x, y, z, w, signed Q16.16.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 out_valid  output  1  out_vec / out_dz hold a completed result.
REQ-009 out_ready  input  1  downstream consumes the result this cycle.
REQ-010 out_vec  output  [0:2][31:0]  NDC x/w, y/w, z/w, signed Q16.16.
REQ-011 out_dz  output  1  w was zero for the vector in out_vec.

Function
REQ-012 States: IDLE, DIV, OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-013 IDLE: on in_valid=1 the four words are captured into internal registers, the component index is set to 0, and the next state is DIV.
REQ-014 DIV: components are processed in order x, y, z.
REQ-015 Each component takes 1 load cycle plus ITERS iterate cycles (49 cycles at default).
REQ-016 After z completes, the next state is OUT.
REQ-017 Latency is fixed at 147 cycles from the accepting edge to the first edge where out_valid=1, for every input, including w=0 and saturating cases.
REQ-018 OUT: out_vec and out_dz stay stable while out_ready=0; on out_ready=1 the next state is IDLE, and a new vector can be accepted one cycle later.
REQ-019 Quotient is trunc((num << FRAC_BITS) / w), rounded toward zero.
REQ-020 The division is computed on magnitudes with a 48-bit dividend; the sign is num_sign XOR w_sign, applied after the division.
REQ-021 A magnitude result above 0x7FFF_FFFF saturates to 0x7FFF_FFFF if positive and to 0x8000_0000 if negative.
REQ-022 Magnitude of 0x8000_0000 (either operand) is treated as 2^31 without overflow.
REQ-023 w = 0 sets out_dz = 1, and each component is set by the sign of its numerator: 0x7FFF_FFFF if positive, 0x8000_0000 if negative, 0 if zero.
REQ-024 Otherwise out_dz = 0.
REQ-025 Inputs arriving while in_ready=0 are ignored; upstream holds them.

Reset
REQ-026 rst=1 at any edge, including mid-DIV or in OUT, puts the block in IDLE and aborts any result.
REQ-027 During and after rst: out_valid=0, out_vec all zero, out_dz=0, in_ready=1 in the cycle after rst deasserts.
REQ-028 No partial result is emitted after reset.

Structure
REQ-029 Shared package gfx_pkg holds:
- fixed-point type fx32_t, vec4_t, vec3_t;
- FX_ONE = 32'h0001_0000, FX_MAX = 32'h7FFF_FFFF, FX_MIN = 32'h8000_0000;
- default ITERS;
- the persp_div state enum.
REQ-030 One sub-module, seq_div: unsigned restoring divider, 48-bit dividend / 32-bit divisor, one quotient bit per cycle.
- Ports: start, done, busy, quotient, divide-by-zero flag.
- Reused for all three components.

Verification
REQ-031 in (0x0002_0000, 0x0004_0000, 0xFFFA_0000, 0x0002_0000) -> after 147 cycles out_vec = (0x0001_0000, 0x0002_0000, 0xFFFD_0000), out_dz=0.
REQ-032 in (0x0001_0000, 0, 0xFFFF_0000, 0xFFFF_0000) -> out_vec = (0xFFFF_0000, 0, 0x0001_0000).
REQ-033 w=0, x=0x0003_0000, y=0, z=0xFFFF_0000 -> out_vec = (0x7FFF_FFFF, 0, 0x8000_0000), out_dz=1, latency 147.
REQ-034 x=0x7FFF_0000, w=0x0000_0100 -> out_vec[0]=0x7FFF_FFFF; x=0x0001_0000, w=0x0003_0000 -> out_vec[0]=0x0000_5555.
REQ-035 out_ready held 0 for 10 cycles in OUT -> out_vec stable, in_ready=0 throughout, new in_valid ignored; release -> IDLE; back-to-back second vector accepted and correct.
REQ-036 rst pulsed at cycle 60 of DIV -> next cycle out_valid=0, in_ready=1; a following vector produces the correct result with no stale data.
